// File: rtl/ins_step_sequencer_pkg.sv
// Purpose: opcode/subcode constants, step limits and the decoded step-info struct for the step sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ins_step_sequencer_pkg;

  localparam int CNT_W_DEF = 3;
  localparam int INS_W_DEF = 16;

  // 5-bit major opcodes (ir_in[15:11])
  localparam logic [4:0] OP_ALU       = 5'b00000;
  localparam logic [4:0] OP_LHI       = 5'b00001;
  localparam logic [4:0] OP_LLI       = 5'b00010;
  localparam logic [4:0] OP_LDRRI     = 5'b00011;
  localparam logic [4:0] OP_LDRRR     = 5'b00100;
  localparam logic [4:0] OP_STRRI     = 5'b00101;
  localparam logic [4:0] OP_CMP_STRRR = 5'b00110;
  localparam logic [4:0] OP_ADDI      = 5'b00111;
  localparam logic [4:0] OP_SUBI      = 5'b01000;
  localparam logic [4:0] OP_MOV       = 5'b01011;
  localparam logic [4:0] OP_JMP       = 5'b10000;
  localparam logic [4:0] OP_JALRL     = 5'b10001;
  localparam logic [4:0] OP_JALRR     = 5'b10010;
  localparam logic [4:0] OP_JR        = 5'b10011;
  localparam logic [4:0] OP_BCC       = 5'b11000;
  localparam logic [4:0] OP_BAL       = 5'b11001;
  localparam logic [4:0] OP_SYS       = 5'b11100;

  // 2-bit subcodes (ir_in[1:0]) that disambiguate shared major opcodes
  localparam logic [1:0] SUB_CMP   = 2'b01;
  localparam logic [1:0] SUB_STRRR = 2'b00;
  localparam logic [1:0] SUB_LDRRR = 2'b00;
  localparam logic [1:0] SUB_OUTR  = 2'b00;
  localparam logic [1:0] SUB_HLT   = 2'b01;

  // Last step of each instruction class; LAST_NONE means buff_pc never fires
  localparam logic [2:0] LAST_NONE  = 3'd0;
  localparam logic [2:0] LAST_NOP   = 3'd1;
  localparam logic [2:0] LAST_SHORT = 3'd2;
  localparam logic [2:0] LAST_ALU   = 3'd3;
  localparam logic [2:0] LAST_STORE = 3'd3;
  localparam logic [2:0] LAST_LOAD  = 3'd4;

  // Counter value that can never be reached in normal sequencing
  localparam logic [2:0] CNT_WRAP = 3'd7;

  typedef struct packed {
    logic [2:0] last;
    logic       is_hlt;
    logic       is_illegal;
  } step_info_t;

endpackage

// File: rtl/ins_step_sequencer_if.sv
// Purpose: groups the fetch-side inputs and sequencer outputs of the step sequencer.
// Latency: n/a (wiring only).
// Backpressure: mem_wait from the memory side stalls the sequencer.
// Ports: ir_in, mem_wait (memory -> sequencer); Cnt, InsM, InsL, buff_pc, halted, illegal (sequencer -> decoders).
interface ins_step_sequencer_if #(
  parameter int CNT_W = 3,
  parameter int INS_W = 16
);
  logic [INS_W-1:0] ir_in;
  logic             mem_wait;
  logic [CNT_W-1:0] Cnt;
  logic [4:0]       InsM;
  logic [1:0]       InsL;
  logic             buff_pc;
  logic             halted;
  logic             illegal;

  // Memory / fetch side
  modport master (
    output ir_in, mem_wait,
    input  Cnt, InsM, InsL, buff_pc, halted, illegal
  );

  // Sequencer side
  modport slave (
    input  ir_in, mem_wait,
    output Cnt, InsM, InsL, buff_pc, halted, illegal
  );
endinterface

// File: rtl/ins_step_sequencer_step_last_lut.sv
// Purpose: decodes latched InsM/InsL into last step, HLT and unknown-opcode indications.
// Latency: combinational.
// Backpressure: none.
// Ports: insm_i, insl_i (latched fields) -> info_o {last, is_hlt, is_illegal}.
module ins_step_sequencer_step_last_lut
  import ins_step_sequencer_pkg::*;
(
  input  logic [4:0] insm_i,
  input  logic [1:0] insl_i,
  output step_info_t info_o
);

  always_comb begin
    info_o.last       = LAST_NOP;
    info_o.is_hlt     = 1'b0;
    info_o.is_illegal = 1'b0;
    case (insm_i)
      OP_LHI, OP_LLI, OP_MOV,
      OP_BCC, OP_BAL, OP_JMP, OP_JALRL, OP_JALRR, OP_JR: info_o.last = LAST_SHORT;
      OP_ALU, OP_ADDI, OP_SUBI:                          info_o.last = LAST_ALU;
      OP_LDRRI:                                          info_o.last = LAST_LOAD;
      OP_STRRI:                                          info_o.last = LAST_STORE;
      OP_CMP_STRRR: begin
        if (insl_i == SUB_CMP)        info_o.last = LAST_ALU;
        else if (insl_i == SUB_STRRR) info_o.last = LAST_STORE;
        else                          info_o.is_illegal = 1'b1;
      end
      OP_LDRRR: begin
        if (insl_i == SUB_LDRRR) info_o.last = LAST_LOAD;
        else                     info_o.is_illegal = 1'b1;
      end
      OP_SYS: begin
        if (insl_i == SUB_OUTR) begin
          info_o.last = LAST_SHORT;
        end else if (insl_i == SUB_HLT) begin
          // HLT never completes: it parks the counter instead of raising buff_pc
          info_o.last   = LAST_NONE;
          info_o.is_hlt = 1'b1;
        end else begin
          info_o.is_illegal = 1'b1;
        end
      end
      default: info_o.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ins_step_sequencer.sv
// Purpose: multicycle step counter plus latched InsM/InsL fields feeding the Signal_* decoders.
// Latency: fields latched on the step-0 edge; Cnt advances one step per clock; buff_pc combinational.
// Backpressure: mem_wait holds Cnt/InsM/InsL at steps 0 and 3, ignored at other steps.
// Ports: clk, rst_n (async active-low); bus (slave modport): ir_in, mem_wait in; Cnt, InsM, InsL,
//        buff_pc, halted, illegal out.
// Option: ILLEGAL_TRAP_EN - unknown opcodes set sticky illegal+halted at step 1 and freeze Cnt at 1;
//         when undefined they run as a 2-step NOP and illegal is tied 0.
module ins_step_sequencer
  import ins_step_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int INS_W = INS_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ins_step_sequencer_if.slave   bus
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       insm_q, insm_d;
  logic [1:0]       insl_q, insl_d;
  logic             halted_q, halted_d;

  step_info_t info;
  logic       at_last;
  logic       trap_now;
  logic       buff_pc;

  ins_step_sequencer_step_last_lut u_lut (
    .insm_i (insm_q),
    .insl_i (insl_q),
    .info_o (info)
  );

  // At step 0 the latch still holds the previous instruction, so never signal completion there
  assign at_last = (cnt_q != '0) && (cnt_q == CNT_W'(info.last));

  // Only the opcode and subcode fields matter to sequencing
  logic unused_ir_bits;
  assign unused_ir_bits = ^bus.ir_in[INS_W-6:2];

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign trap_now = info.is_illegal && (cnt_q == CNT_W'(1));
  assign buff_pc  = at_last && !info.is_illegal;
`else
  logic unused_illegal;
  assign unused_illegal = info.is_illegal;
  assign trap_now       = 1'b0;
  assign buff_pc        = at_last;
`endif

  always_comb begin
    cnt_d    = cnt_q;
    insm_d   = insm_q;
    insl_d   = insl_q;
    halted_d = halted_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    if (halted_q) begin
      // frozen until reset
    end else if (cnt_q == CNT_W'(CNT_WRAP)) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      if (!bus.mem_wait) begin
        insm_d = bus.ir_in[15:11];
        insl_d = bus.ir_in[1:0];
        cnt_d  = CNT_W'(1);
      end
    end else if ((cnt_q == CNT_W'(3)) && bus.mem_wait) begin
      // memory stall at the data-access step
    end else if (info.is_hlt && (cnt_q == CNT_W'(2))) begin
      halted_d = 1'b1;
    end else if (trap_now) begin
      halted_d = 1'b1;
`ifdef ILLEGAL_TRAP_EN
      illegal_d = 1'b1;
`endif
    end else if (buff_pc) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      insm_q   <= '0;
      insl_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      insm_q   <= insm_d;
      insl_q   <= insl_d;
      halted_q <= halted_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end
  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.Cnt     = cnt_q;
  assign bus.InsM    = insm_q;
  assign bus.InsL    = insl_q;
  assign bus.buff_pc = buff_pc;
  assign bus.halted  = halted_q;

endmodule
